// File: rtl/fb_pkg.sv
// Framebuffer write-arbiter package.
// Holds the framebuffer geometry, the default address/pixel widths derived
// from it, and the arbiter state encoding shared by the arbiter RTL.
package fb_pkg;

    localparam int FB_WIDTH  = 1280;
    localparam int FB_HEIGHT = 720;
    localparam int FB_TOTPIX = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = $clog2(FB_TOTPIX);
    localparam int FB_DATA_W = 24;                  // RGB888

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans requesters starting at (ptr_i+1) mod NREQ and wraps, so the
// requester at ptr_i itself has the lowest priority.
//   req_i  in  NREQ  request vector
//   ptr_i  in  IDW   last-granted index
//   gnt_o  out NREQ  onehot winner (all zero when nothing requests)
//   idx_o  out IDW   winner index
//   any_o  out 1     some requester is asserted
module rr_pick
    import fb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(ptr_i) + 32'(k)) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter for the single vram write port.
// Requesters are granted in bursts of up to MAX_BURST beats; accepted beats
// are written through one registered port (1-cycle latency). Beats whose
// address is >= TOTPIX are accepted but dropped, and set sticky err_oob.
// Optional build macro FB_ARB_VBLANK_GATE_EN: new grants only start while
// vblank is high; a running burst is never cut by vblank.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/last    NREQ         per-requester beat valid / end of burst
//   req_addr/data     NREQ*ADDR_W / NREQ*DATA_W, requester i at [i*W +: W]
//   req_ready         NREQ         beat accept, onehot0
//   vblank            1            vertical blank (gate build only)
//   vram_we/addr/data              registered vram write port
//   grant_id          current or last owner
//   busy              high while a grant is held
//   err_oob           sticky out-of-range flag
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = FB_ADDR_W,
    parameter int DATA_W    = FB_DATA_W,
    parameter int TOTPIX    = FB_TOTPIX,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     vblank,
    output logic                     vram_we,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [DATA_W-1:0]        vram_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic                     err_oob
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    // One extra bit so TOTPIX == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] TOT_LIM = (ADDR_W + 1)'(TOTPIX);
    localparam logic [CW-1:0]   CAP     = CW'(MAX_BURST);

    arb_state_t        state_q;
    logic [IDW-1:0]    ptr_q, gid_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   ready_q;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic [NREQ-1:0]   pick_oh;
    logic [IDW-1:0]    pick_idx;
    logic              pick_any, arb_ok;

    logic [ADDR_W-1:0] addr_a [NREQ];
    logic [DATA_W-1:0] data_a [NREQ];
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              acc, cur_last, in_range;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_a[g] = req_data[g*DATA_W +: DATA_W];
    end

`ifdef FB_ARB_VBLANK_GATE_EN
    assign arb_ok = vblank;
`else
    assign arb_ok = 1'b1;
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Everything below is keyed off the registered owner, so ready never
    // has a combinational path from req_valid.
    assign cur_addr = addr_a[gid_q];
    assign cur_data = data_a[gid_q];
    assign cur_last = req_last[gid_q];
    assign acc      = (state_q == ARB_GRANT) && req_valid[gid_q];
    assign in_range = {1'b0, cur_addr} < TOT_LIM;
    assign cnt_d    = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= IDW'(NREQ - 1);      // requester 0 wins first
            gid_q   <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any && arb_ok) begin
                        state_q <= ARB_GRANT;
                        gid_q   <= pick_idx;
                        ptr_q   <= pick_idx;
                        cnt_q   <= '0;
                        ready_q <= pick_oh;
                    end
                end
                ARB_GRANT: begin
                    // A dropped valid just stalls; only last or the cap release.
                    if (acc) begin
                        cnt_q <= cnt_d;
                        if (in_range) begin
                            we_q   <= 1'b1;
                            addr_q <= cur_addr;
                            data_q <= cur_data;
                        end else begin
                            err_q  <= 1'b1;
                        end
                        if (cur_last || cnt_d == CAP) begin
                            state_q <= ARB_IDLE;
                            ready_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    ready_q <= '0;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign vram_we   = we_q;
    assign vram_addr = addr_q;
    assign vram_data = data_q;
    assign grant_id  = gid_q;
    assign busy      = (state_q == ARB_GRANT);
    assign err_oob   = err_q;

endmodule
